// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow.
// It processes the operands LSB first and reports the result through a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             bit_a;
    logic             bit_b;
    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] res_next;

    assign bit_a    = a_sr_q[0];
    assign bit_b    = b_sr_q[0];
    assign cell_d   = bit_a ^ bit_b ^ br_q;
    assign cell_b   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    assign res_next = {cell_d, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = minuend;
                    b_sr_d   = subtrahend;
                    res_sr_d = '0;
                    br_d     = bin;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                br_d     = cell_b;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Publish on the last bit so diff is valid alongside done.
                    state_d = DONE;
                    diff_d  = res_next;
                    bout_d  = cell_b;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back random checks for serial_subtractor.
// It uses WIDTH=8 with a 10 ns clock, and it drives and samples on the falling edge.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] minuend = '0;
    logic [W-1:0] subtrahend = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .bout       (bout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and watch 12 falling edges after the accept edge.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic eb);
        int lat;
        int bcnt;
        int dcnt;
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        @(negedge sys_clk);
        start      = 1'b1;
        minuend    = a;
        subtrahend = b;
        bin        = bi;
        @(negedge sys_clk);
        start      = 1'b0;
        minuend    = 8'h5A;
        subtrahend = 8'hC3;
        bin        = ~bi;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = k;
                    chk({tag, "_diff"}, 32'(diff), 32'(ed));
                    chk({tag, "_bout"}, 32'(bout), 32'(eb));
                end
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(W));
        chk({tag, "_busy"}, 32'(bcnt), 32'(W + 1));
        chk({tag, "_ndone"}, 32'(dcnt), 32'd1);
    endtask

    initial begin
        bit        stable;
        bit        held;
        int        dcnt;
        int        ops;
        int        last;
        int        cyc;
        logic [8:0] q_exp[$];
        logic [8:0] e;

        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);

        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (busy || done || diff != 0 || bout) stable = 1'b0;
        end
        chk("idle_stable", 32'(stable), 32'd1);

        run_op("op100_37", 8'd100, 8'd37, 1'b0, 8'h3F, 1'b0);
        run_op("op5_9", 8'd5, 8'd9, 1'b0, 8'hFC, 1'b1);
        run_op("op0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op("opff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // start pulses during CALC must be ignored; diff 0x00 must hold
        @(negedge sys_clk);
        start      = 1'b1;
        minuend    = 8'h50;
        subtrahend = 8'h20;
        bin        = 1'b0;
        held = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge sys_clk);
            if (k == 2 || k == 4) begin
                start      = 1'b1;
                minuend    = 8'h11;
                subtrahend = 8'h99;
                bin        = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy && !done && diff != 8'h00) held = 1'b0;
            if (done) begin
                dcnt++;
                chk("busy_ign_diff", 32'(diff), 32'h30);
                chk("busy_ign_bout", 32'(bout), 32'd0);
            end
        end
        chk("busy_ign_hold", 32'(held), 32'd1);
        chk("busy_ign_ndone", 32'(dcnt), 32'd1);

        // async reset in the middle of CALC
        @(negedge sys_clk);
        start      = 1'b1;
        minuend    = 8'h0F;
        subtrahend = 8'h01;
        bin        = 1'b0;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("pre_arst_busy", 32'(busy), 32'd1);
        chk("pre_arst_diff", 32'(diff), 32'h30);
        sys_rst_n = 1'b0;
        #2;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        #1;
        sys_rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge sys_clk);
            if (done || busy) dcnt++;
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);
        run_op("op200_1", 8'd200, 8'd1, 1'b0, 8'd199, 1'b0);

        // back-to-back random operations with start held high
        @(negedge sys_clk);
        minuend    = W'($urandom);
        subtrahend = W'($urandom);
        bin        = 1'($urandom);
        start      = 1'b1;
        e = {1'b0, minuend} - {1'b0, subtrahend} - {8'd0, bin};
        q_exp.push_back(e);
        ops  = 0;
        last = -1;
        cyc  = 0;
        while (ops < 1000 && cyc < 12000) begin
            @(negedge sys_clk);
            cyc++;
            if (done) begin
                e = q_exp.pop_front();
                chk("rnd_res", 32'({bout, diff}), 32'(e));
                if (last >= 0) chk("rnd_gap", 32'(cyc - last), 32'd10);
                last = cyc;
                ops++;
                if (ops < 1000) begin
                    minuend    = W'($urandom);
                    subtrahend = W'($urandom);
                    bin        = 1'($urandom);
                    e = {1'b0, minuend} - {1'b0, subtrahend} - {8'd0, bin};
                    q_exp.push_back(e);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("rnd_ops", 32'(ops), 32'd1000);

        repeat (3) @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
